// File: rtl/conv_data_dispatch.sv
// conv_data_dispatch
// Buffers a burst of source beats and forwards them to one of four
// destinations on a shared data bus. The destination is chosen by a one-hot
// select that is latched when start is accepted. Beats pass through a small
// internal FIFO, so the source may run ahead of a stalled destination by up to
// FIFO_DEPTH beats. There is no bypass path: a beat accepted in cycle N is
// presented at the earliest in cycle N+1.
//
// Ports
//   system_clk  : clock, rising edge
//   rst_n       : asynchronous active-low reset
//   start       : one-cycle burst request (acted on only in IDLE)
//   select[3:0] : one-hot destination, sampled with start
//   burst_len   : beats in the burst, sampled with start (0 is rejected)
//   in_data     : source beat, FEATURE_WIDTH*8 bits
//   in_valid    : source beat valid
//   in_ready    : beat accepted this cycle when in_valid is also high
//   out_data    : FIFO head, shared by all destinations
//   out_valid   : per-destination valid, only the latched destination's bit
//   out_ready   : per-destination ready; unselected bits are ignored
//   busy        : high in RUN and DONE
//   done        : one-cycle pulse in the DONE state
//   err         : one-cycle pulse the cycle after a rejected start
module conv_data_dispatch #(
  parameter int unsigned FEATURE_WIDTH = 16,
  parameter int unsigned FIFO_DEPTH    = 4
) (
  input  logic                       system_clk,
  input  logic                       rst_n,
  input  logic                       start,
  input  logic [3:0]                 select,
  input  logic [15:0]                burst_len,
  input  logic [FEATURE_WIDTH*8-1:0] in_data,
  input  logic                       in_valid,
  output logic                       in_ready,
  output logic [FEATURE_WIDTH*8-1:0] out_data,
  output logic [3:0]                 out_valid,
  input  logic [3:0]                 out_ready,
  output logic                       busy,
  output logic                       done,
  output logic                       err
);

  localparam int unsigned DW = FEATURE_WIDTH * 8;
  localparam int unsigned AW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int unsigned CW = AW + 1;
  localparam int unsigned LW = 16;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t          state;
  state_t          state_nxt;

  logic [3:0]      sel_q;
  logic [LW-1:0]   len_q;
  logic [LW-1:0]   in_cnt;
  logic [LW-1:0]   out_cnt;

  logic [DW-1:0]   mem [FIFO_DEPTH];
  logic [AW-1:0]   wr_ptr;
  logic [AW-1:0]   rd_ptr;
  logic [CW-1:0]   count;

  logic            start_ok_c;
  logic            accept_c;
  logic            fifo_full_c;
  logic            fifo_empty_c;
  logic            push_c;
  logic            pop_c;
  logic            last_pop_c;

  // A start is legal only with exactly one destination and a non-empty burst.
  assign start_ok_c   = (select != 4'd0) &&
                        ((select & (select - 4'd1)) == 4'd0) &&
                        (burst_len != LW'(0));
  assign accept_c     = (state == IDLE) && start && start_ok_c;

  assign fifo_full_c  = (count == CW'(FIFO_DEPTH));
  assign fifo_empty_c = (count == CW'(0));

  // Flow control depends on registered state only, never on out_ready.
  assign in_ready  = (state == RUN) && !fifo_full_c && (in_cnt < len_q);
  assign out_valid = ((state == RUN) && !fifo_empty_c) ? sel_q : 4'b0000;
  assign out_data  = mem[rd_ptr];

  assign push_c     = in_valid && in_ready;
  assign pop_c      = |(out_valid & out_ready);
  // out_cnt < len_q <= 16'hFFFF while popping, so the increment cannot wrap.
  assign last_pop_c = pop_c && ((out_cnt + LW'(1)) == len_q);

  assign busy = (state != IDLE);
  assign done = (state == DONE);

  // State register.
  always_ff @(posedge system_clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // Next-state logic.
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (accept_c)   state_nxt = RUN;
      RUN:     if (last_pop_c) state_nxt = DONE;
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Burst parameters, beat counters and the rejected-start pulse.
  always_ff @(posedge system_clk or negedge rst_n) begin
    if (!rst_n) begin
      sel_q   <= 4'b0000;
      len_q   <= LW'(0);
      in_cnt  <= LW'(0);
      out_cnt <= LW'(0);
      err     <= 1'b0;
    end else begin
      err <= (state == IDLE) && start && !start_ok_c;
      if (accept_c) begin
        sel_q   <= select;
        len_q   <= burst_len;
        in_cnt  <= LW'(0);
        out_cnt <= LW'(0);
      end else begin
        if (push_c) in_cnt  <= in_cnt + LW'(1);
        if (pop_c)  out_cnt <= out_cnt + LW'(1);
      end
    end
  end

  // Beat FIFO; storage is cleared on reset so out_data reads zero afterwards.
  always_ff @(posedge system_clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= AW'(0);
      rd_ptr <= AW'(0);
      count  <= CW'(0);
      for (int i = 0; i < int'(FIFO_DEPTH); i++) begin
        mem[i] <= DW'(0);
      end
    end else if (accept_c) begin
      wr_ptr <= AW'(0);
      rd_ptr <= AW'(0);
      count  <= CW'(0);
    end else begin
      if (push_c) begin
        mem[wr_ptr] <= in_data;
        wr_ptr      <= wr_ptr + AW'(1);
      end
      if (pop_c) begin
        rd_ptr <= rd_ptr + AW'(1);
      end
      case ({push_c, pop_c})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase
    end
  end

endmodule
